// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder with valid/ready handshakes on both sides.
// Each stage adds one SW-bit slice; the carry and the skewed operands/sums travel in registers.
module cla_pipe_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  // Slice adder built from 4-bit lookahead groups; group carries chain across the slice.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          c);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW:0]   cv;
    logic          gg;
    logic          pg;
    g     = a & b;
    p     = a ^ b;
    cv    = '0;
    cv[0] = c;
    for (int k = 0; k < SW / 4; k++) begin
      cv[4*k+1] = g[4*k] | (p[4*k] & cv[4*k]);
      cv[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cv[4*k]);
      cv[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                | (p[4*k+2] & p[4*k+1] & p[4*k] & cv[4*k]);
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg = &p[4*k +: 4];
      cv[4*k+4] = gg | (pg & cv[4*k]);
    end
    return {cv[SW], p ^ cv[SW-1:0]};
  endfunction

  logic              adv;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // The whole pipe advances as one; a stalled output freezes every stage.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];

  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int SUMW = (gi + 1) * SW;

    logic [SW-1:0]   a_sl;
    logic [SW-1:0]   b_sl;
    logic            c_in;
    logic [SW:0]     res;
    logic [SUMW-1:0] sum_d;
    logic [SUMW-1:0] sum_q;
    logic            c_q;

    assign res = cla_slice(a_sl, b_sl, c_in);

    if (gi == 0) begin : g_first
      assign a_sl  = in_a[SW-1:0];
      assign b_sl  = in_b[SW-1:0];
      assign c_in  = cin;
      assign sum_d = res[SW-1:0];
    end else begin : g_next
      assign a_sl  = g_stage[gi-1].g_fwd.a_up_q[SW-1:0];
      assign b_sl  = g_stage[gi-1].g_fwd.b_up_q[SW-1:0];
      assign c_in  = g_stage[gi-1].c_q;
      assign sum_d = {res[SW-1:0], g_stage[gi-1].sum_q};
    end

    always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        sum_q <= sum_d;
        c_q   <= res[SW];
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      // Operand bits still to be added by later stages.
      localparam int UPW = WIDTH - (gi + 1) * SW;
      logic [UPW-1:0] a_up_d;
      logic [UPW-1:0] b_up_d;
      logic [UPW-1:0] a_up_q;
      logic [UPW-1:0] b_up_q;

      if (gi == 0) begin : g_src
        assign a_up_d = in_a[WIDTH-1:SW];
        assign b_up_d = in_b[WIDTH-1:SW];
      end else begin : g_src
        assign a_up_d = g_stage[gi-1].g_fwd.a_up_q[UPW+SW-1:SW];
        assign b_up_d = g_stage[gi-1].g_fwd.b_up_q[UPW+SW-1:SW];
      end

      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
          a_up_q <= '0;
          b_up_q <= '0;
        end else if (adv) begin
          a_up_q <= a_up_d;
          b_up_q <= b_up_d;
        end
      end
    end else begin : g_last
      logic a_msb;
      logic b_msb;
      logic ovf_d;
      logic ovf_q;

      if (gi == 0) begin : g_msb
        assign a_msb = in_a[WIDTH-1];
        assign b_msb = in_b[WIDTH-1];
      end else begin : g_msb
        assign a_msb = g_stage[gi-1].g_fwd.a_up_q[SW-1];
        assign b_msb = g_stage[gi-1].g_fwd.b_up_q[SW-1];
      end

      assign ovf_d = (a_msb == b_msb) && (sum_d[SUMW-1] != a_msb);

      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end

      assign sum  = sum_q;
      assign cout = c_q;
      assign ovf  = ovf_q;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Random and directed stimulus for cla_pipe_adder; expected results are queued
// at acceptance and consumed by an independent output monitor.
module tb_cla_pipe_adder;
  localparam int W = 64;

  logic         CLK = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  logic [W+1:0] sb_q[$];
  bit rand_done;

  always #5 CLK = ~CLK;

  cla_pipe_adder #(.WIDTH(W), .STAGES(4)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Reference: plain 65-bit arithmetic plus the signed-overflow rule; packed as {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] full;
    logic       o;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    o    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {o, full};
  endfunction

  task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [W+1:0] e;
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, expected no result", sum, cout, ovf);
      end else begin
        e = sb_q.pop_front();
        chk("result", {ovf, cout, sum}, e);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    cin      = c;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        sb_q.push_back(model(a, b, c));
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
    end
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge CLK);
    #1;
    chk(nm, sb_q.size(), 0);
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [W+1:0] snap;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout_ovf", {cout, ovf}, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge CLK); #2 reset_n = 1'b1;
    @(posedge CLK); #1;

    // Basic add and latency: visible after the 4th edge counting the accept edge.
    send(64'd1, 64'd2, 1'b0);
    repeat (2) @(posedge CLK);
    #1 chk("latency_early", out_valid, 0);
    @(posedge CLK);
    #1 chk("latency_valid", out_valid, 1);
    chk("basic_sum", {ovf, cout, sum}, 66'd3);
    @(posedge CLK);
    #1 chk("single_pulse", out_valid, 0);

    // Corner cases
    send({W{1'b1}}, 64'd0, 1'b1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1);
    wait_drain("corner_drain");

    for (int i = 0; i < 16; i++) send(rnd64(), rnd64(), 1'($urandom()));
    wait_drain("stream_drain");

    // Backpressure: fill the pipe with out_ready low, then hold 3 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(rnd64(), rnd64(), 1'($urandom()));
    chk("bp_full_valid", out_valid, 1);
    snap     = {ovf, cout, sum};
    in_valid = 1'b1;
    in_a     = rnd64();
    in_b     = rnd64();
    cin      = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {out_valid, ovf, cout, sum}, {1'b1, snap});
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    send(in_a, in_b, cin);
    wait_drain("bp_drain");

    // Random gaps with a randomly stalling consumer.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(2) == 0) begin
            @(posedge CLK);
            #1;
          end
          send(rnd64(), rnd64(), 1'($urandom()));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge CLK);
          #1 out_ready = 1'($urandom());
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("random_drain");

    // Asynchronous reset with two operations in flight.
    out_ready = 1'b0;
    send(64'd100, 64'd200, 1'b0);
    send(64'd300, 64'd400, 1'b1);
    repeat (2) @(posedge CLK);
    #1 chk("rst_pre_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_sum", sum, 0);
    @(posedge CLK); #2 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    send(64'd5, 64'd7, 1'b1);
    repeat (2) @(posedge CLK);
    #1 chk("rst_new_early", out_valid, 0);
    @(posedge CLK);
    #1 chk("rst_new_valid", out_valid, 1);
    chk("rst_new_sum", {ovf, cout, sum}, 66'd13);
    repeat (10) @(posedge CLK);
    #1 chk("rst_no_stale", sb_q.size(), 0);
    chk("rst_idle_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
